// File: rtl/minterm_enum.sv
// ============================================================================
// Module   : minterm_enum
// Brief    : Walks a 2^N-bit truth table and hands out, one per valid/ready
//            handshake, every input vector whose table bit is set, ascending.
//            Optional macro MINTERM_ENUM_MAXTERM_EN adds a `mode` input that
//            selects maxterm enumeration (table bits that are clear).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module minterm_enum #(
  parameter int N  = 3,
  parameter int CW = N + 1
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef MINTERM_ENUM_MAXTERM_EN
  input  logic            mode,
`endif
  input  logic            start,
  input  logic [2**N-1:0] tbl,
  output logic [N-1:0]    out_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic [CW-1:0]   count
);

  localparam logic [N-1:0] c_last_idx = {N{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2**N-1:0] r_tbl;
  logic [N-1:0]    r_idx;
  logic [N-1:0]    r_out_x;
  logic [CW-1:0]   r_count;
  logic            w_hit;
  logic            w_last;

`ifdef MINTERM_ENUM_MAXTERM_EN
  logic            r_mode;
  // In maxterm mode a cleared table bit is the one being reported.
  assign w_hit = r_tbl[r_idx] ^ r_mode;
`else
  assign w_hit = r_tbl[r_idx];
`endif

  assign w_last = (r_idx == c_last_idx);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = SCAN;
      SCAN: begin
        if (w_hit)       w_state_nxt = OUT;
        else if (w_last) w_state_nxt = DONE;
      end
      OUT:  if (out_ready) w_state_nxt = w_last ? DONE : SCAN;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tbl   <= '0;
      r_idx   <= '0;
      r_out_x <= '0;
      r_count <= '0;
`ifdef MINTERM_ENUM_MAXTERM_EN
      r_mode  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_tbl   <= tbl;
            r_idx   <= '0;
            r_count <= '0;
`ifdef MINTERM_ENUM_MAXTERM_EN
            r_mode  <= mode;
`endif
          end
        end
        SCAN: begin
          if (w_hit)        r_out_x <= r_idx;
          else if (!w_last) r_idx   <= r_idx + N'(1);
        end
        OUT: begin
          // The index stops at the last entry; the run ends instead of wrapping.
          if (out_ready) begin
            r_count <= r_count + CW'(1);
            if (!w_last) r_idx <= r_idx + N'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_x     = r_out_x;
  assign out_valid = (r_state == OUT);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_minterm_enum.sv
// ============================================================================
// Module   : tb_minterm_enum
// Brief    : Directed, table-driven bench for minterm_enum (N=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_minterm_enum;

  localparam int N  = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [7:0]    tbl = 8'h00;
  logic          out_ready = 1'b0;
  logic [N-1:0]  out_x;
  logic          out_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  minterm_enum #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MINTERM_ENUM_MAXTERM_EN
    .mode      (mode),
`endif
    .start     (start),
    .tbl       (tbl),
    .out_x     (out_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  // Cycle numbering: the cycle in which start is presented is cycle 1.
  typedef struct {
    string          name;
    logic [7:0]     tbl;
    logic           mode;
    int             stall;     // cycles out_ready stays low per output
    int             poke_cyc;  // cycle of a stray start pulse (0 = none)
    logic [7:0]     poke_tbl;
    int             n;
    logic [7:0][2:0] xs;       // xs[i] = i-th expected output
    int             first_cyc; // -1 = no out_valid expected
    int             done_cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check({name, " valid seen"}, 32'(out_valid), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int         cycle;
    int         got;
    int         hold;
    int         first;
    bit         seen_done;
    bit         stall_bad;
    logic [2:0] held;
    @(negedge clk);
    tbl       = v.tbl;
    mode      = v.mode;
    start     = 1'b1;
    out_ready = (v.stall == 0);
    cycle = 1; got = 0; hold = 0; first = -1; seen_done = 0; stall_bad = 0; held = '0;
    while (!seen_done && cycle < 200) begin
      @(negedge clk);
      cycle++;
      start = (cycle == v.poke_cyc);
      if (start) tbl = v.poke_tbl;
      if (out_valid) begin
        if (first < 0) first = cycle;
        if (hold > 0 && out_x !== held) stall_bad = 1;
        held = out_x;
        if (hold >= v.stall) begin
          out_ready = 1'b1;
          if (got < v.n)
            check($sformatf("%s x[%0d]", v.name, got), 32'(out_x), 32'(v.xs[got]));
          got++;
          hold = 0;
        end else begin
          out_ready = 1'b0;
          hold++;
        end
      end else begin
        out_ready = (v.stall == 0);
      end
      if (done) begin
        seen_done = 1;
        check({v.name, " done cycle"}, 32'(cycle), 32'(v.done_cyc));
        check({v.name, " count"}, 32'(count), 32'(v.n));
      end
    end
    check({v.name, " finished in budget"}, 32'(seen_done), 32'd1);
    check({v.name, " outputs"}, 32'(got), 32'(v.n));
    check({v.name, " first valid cycle"}, 32'(first), 32'(v.first_cyc));
    check({v.name, " stable while stalled"}, 32'(stall_bad), 32'd0);
    start = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check({v.name, " done one cycle"}, 32'(done), 32'd0);
    check({v.name, " idle after"}, 32'(busy), 32'd0);
    check({v.name, " count held"}, 32'(count), 32'(v.n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{name:"eval", tbl:8'b0100_0110, mode:1'b0, stall:0, poke_cyc:0, poke_tbl:8'h00,
                     n:3, xs:{15'd0, 3'd6, 3'd2, 3'd1}, first_cyc:4, done_cyc:13});
    vecs.push_back('{name:"backpressure", tbl:8'b0100_0110, mode:1'b0, stall:5, poke_cyc:0, poke_tbl:8'h00,
                     n:3, xs:{15'd0, 3'd6, 3'd2, 3'd1}, first_cyc:4, done_cyc:28});
    vecs.push_back('{name:"empty", tbl:8'h00, mode:1'b0, stall:0, poke_cyc:0, poke_tbl:8'h00,
                     n:0, xs:24'd0, first_cyc:-1, done_cyc:10});
    vecs.push_back('{name:"full", tbl:8'hFF, mode:1'b0, stall:0, poke_cyc:0, poke_tbl:8'h00,
                     n:8, xs:{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, first_cyc:3, done_cyc:18});
    vecs.push_back('{name:"a5", tbl:8'hA5, mode:1'b0, stall:0, poke_cyc:0, poke_tbl:8'h00,
                     n:4, xs:{12'd0, 3'd7, 3'd5, 3'd2, 3'd0}, first_cyc:3, done_cyc:14});
    vecs.push_back('{name:"start in scan", tbl:8'h80, mode:1'b0, stall:0, poke_cyc:4, poke_tbl:8'h01,
                     n:1, xs:{21'd0, 3'd7}, first_cyc:10, done_cyc:11});
`ifdef MINTERM_ENUM_MAXTERM_EN
    vecs.push_back('{name:"maxterm", tbl:8'b0100_0110, mode:1'b1, stall:0, poke_cyc:0, poke_tbl:8'h00,
                     n:5, xs:{9'd0, 3'd7, 3'd5, 3'd4, 3'd3, 3'd0}, first_cyc:3, done_cyc:15});
`endif

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy",      32'(busy),      32'd0);
    check("reset done",      32'(done),      32'd0);
    check("reset count",     32'(count),     32'd0);
    check("reset out_x",     32'(out_x),     32'd0);

    // Reset asserted while an output is pending and count is non-zero.
    tbl = 8'h06; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_valid("rst seq 1st");
    check("rst seq 1st x", 32'(out_x), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    wait_valid("rst seq 2nd");
    check("rst seq 2nd x", 32'(out_x), 32'd2);
    check("rst seq count before", 32'(count), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-run reset out_valid", 32'(out_valid), 32'd0);
    check("mid-run reset busy",      32'(busy),      32'd0);
    check("mid-run reset count",     32'(count),     32'd0);
    check("mid-run reset out_x",     32'(out_x),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
